// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared types and helpers for the code -> one-hot decoder family.
//   Contents:
//     DEC_SEL_W    default code width
//     dec_state_t  pulse FSM states {IDLE, DRIVE, GAP}
//     out_w()      one-hot width for a given code width (1 << sel_w)
//     max_u()      max of two unsigned ints, used to size down-counters
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int unsigned DEC_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dec_state_t;

    function automatic int unsigned out_w(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/decoder_3to8_pulse_if.sv
// -----------------------------------------------------------------------------
// decoder_3to8_pulse_if
//   Valid/ready code input plus pulse outputs of the 3-to-8 pulse decoder.
//   Optional feature macro: DEC_PARITY_EN (adds in_par and err).
//   Signals:
//     in_code     source -> decoder  code to decode
//     in_valid    source -> decoder  code present
//     in_ready    decoder -> source  decoder can accept
//     onehot_out  decoder -> sink    registered one-hot line
//     busy        decoder -> sink    high in DRIVE and GAP
//     done        decoder -> sink    pulse on last DRIVE cycle
//     in_par      source -> decoder  even parity over in_code (DEC_PARITY_EN)
//     err         decoder -> sink    parity error pulse (DEC_PARITY_EN)
//   Modports: master (code source side), slave (decoder side).
// -----------------------------------------------------------------------------
interface decoder_3to8_pulse_if #(
    parameter int unsigned SEL_W = decoder_pkg::DEC_SEL_W
);
    import decoder_pkg::*;

    localparam int unsigned OUT_W = out_w(SEL_W);

    logic [SEL_W-1:0] in_code;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] onehot_out;
    logic             busy;
    logic             done;
`ifdef DEC_PARITY_EN
    logic             in_par;
    logic             err;

    modport master (
        output in_code, in_valid, in_par,
        input  in_ready, onehot_out, busy, done, err
    );
    modport slave (
        input  in_code, in_valid, in_par,
        output in_ready, onehot_out, busy, done, err
    );
`else
    modport master (
        output in_code, in_valid,
        input  in_ready, onehot_out, busy, done
    );
    modport slave (
        input  in_code, in_valid,
        output in_ready, onehot_out, busy, done
    );
`endif

endinterface

// File: rtl/decoder_onehot.sv
// -----------------------------------------------------------------------------
// decoder_onehot
//   Purely combinational binary code -> one-hot decode. Shared by decoders.
//   Ports:
//     i_code    in   SEL_W  binary code
//     o_onehot  out  OUT_W  1 << i_code
// -----------------------------------------------------------------------------
module decoder_onehot
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = DEC_SEL_W
) (
    input  logic [SEL_W-1:0]         i_code,
    output logic [out_w(SEL_W)-1:0]  o_onehot
);

    always_comb begin
        o_onehot         = '0;
        o_onehot[i_code] = 1'b1;
    end

endmodule

// File: rtl/decoder_3to8_pulse.sv
// -----------------------------------------------------------------------------
// decoder_3to8_pulse
//   Accepts a code over valid/ready, then drives 1 << code on onehot_out for
//   PULSE_LEN cycles followed by GAP_LEN idle cycles. One code in flight.
//   Optional feature macro: DEC_PARITY_EN -- codes failing even parity are
//   consumed without a pulse and flagged on err for one cycle.
//   Ports:
//     clk    in  clock, rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    decoder_3to8_pulse_if.slave (code handshake and pulse outputs)
// -----------------------------------------------------------------------------
module decoder_3to8_pulse
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W     = DEC_SEL_W,
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decoder_3to8_pulse_if.slave   bus
);

    localparam int unsigned OUT_W = out_w(SEL_W);
    localparam int unsigned CNT_W = $clog2(max_u(PULSE_LEN, GAP_LEN) + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    // GAP_LEN == 0 never enters GAP; keep the load value well defined anyway.
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
    localparam logic             ONE_PULSE  = (PULSE_LEN == 1);

    dec_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_onehot;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    logic [OUT_W-1:0] w_onehot;
    logic             w_accept;
    logic             w_par_bad;
    logic             w_start;

    decoder_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .i_code   (bus.in_code),
        .o_onehot (w_onehot)
    );

    // r_ready is only ever set in IDLE, so accept implies IDLE.
    assign w_accept = bus.in_valid & r_ready;

`ifdef DEC_PARITY_EN
    logic r_err;
    assign w_par_bad = ^{bus.in_code, bus.in_par};
    assign bus.err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & w_par_bad;
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_start = w_accept & ~w_par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_start) begin
                        r_state  <= DRIVE;
                        r_onehot <= w_onehot;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
                        r_cnt    <= PULSE_LOAD;
                        r_done   <= ONE_PULSE;
                    end
                end
                DRIVE: begin
                    if (r_cnt == '0) begin
                        r_onehot <= '0;
                        if (GAP_LEN > 0) begin
                            r_state <= GAP;
                            r_cnt   <= GAP_LOAD;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        // Next cycle is the last DRIVE cycle.
                        r_done <= (r_cnt == CNT_W'(1));
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_onehot <= '0;
                    r_busy   <= 1'b0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_ready;
    assign bus.onehot_out = r_onehot;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// -----------------------------------------------------------------------------
// tb_decoder_3to8_pulse
//   Bench for decoder_3to8_pulse. DUT A uses PULSE_LEN=4, GAP_LEN=1 and is
//   tracked by a timeline model (cycles since last accept); DUT B uses
//   PULSE_LEN=1, GAP_LEN=0 for the back-to-back short-pulse case.
//   Optional feature macro: DEC_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_decoder_3to8_pulse;
    import decoder_pkg::*;

    localparam int P  = 4;
    localparam int G  = 1;
    localparam int NO = 1000;  // "no accept in recent history"

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_3to8_pulse_if #(.SEL_W(3)) ifa ();
    decoder_3to8_pulse_if #(.SEL_W(3)) ifb ();

    decoder_3to8_pulse #(
        .SEL_W     (3),
        .PULSE_LEN (P),
        .GAP_LEN   (G)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    decoder_3to8_pulse #(
        .SEL_W     (3),
        .PULSE_LEN (1),
        .GAP_LEN   (0)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Timeline model of DUT A: position relative to the last accept edge.
    int         m_since = NO;
    int         m_after = 0;   // edges since reset release
    logic [2:0] m_code  = '0;
    bit         m_rdy   = 1'b0;
    bit         m_err   = 1'b0;

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_a(input logic [2:0] c, input logic v);
        ifa.in_code  = c;
        ifa.in_valid = v;
`ifdef DEC_PARITY_EN
        ifa.in_par = ^c;
`endif
    endtask

    task automatic set_b(input logic [2:0] c, input logic v);
        ifb.in_code  = c;
        ifb.in_valid = v;
`ifdef DEC_PARITY_EN
        ifb.in_par = ^c;
`endif
    endtask

    // Advance one clock, update the model, compare DUT A against it.
    task automatic step(input string tag);
        bit         acc;
        bit         bad;
        logic [2:0] c;
        logic [7:0] e_onehot;
        bit         e_busy;
        bit         e_done;
        bit         e_rdy;
        acc = (ifa.in_valid === 1'b1) && m_rdy;
        c   = ifa.in_code;
        bad = 1'b0;
`ifdef DEC_PARITY_EN
        bad = ^{c, ifa.in_par};
`endif
        @(posedge clk);
        #1;
        cyc++;
        if (m_since < NO) m_since++;
        if (acc && !bad) begin
            m_since = 1;
            m_code  = c;
        end
        m_after++;
        m_err    = acc && bad;
        e_onehot = (m_since >= 1 && m_since <= P) ? (8'h01 << m_code) : 8'h00;
        e_busy   = (m_since >= 1 && m_since <= P + G);
        e_done   = (m_since == P);
        e_rdy    = (m_after >= 1) && (m_since > P + G);
        chk({tag, "/onehot"}, 32'(ifa.onehot_out), 32'(e_onehot));
        chk({tag, "/busy"},   32'(ifa.busy),       32'(e_busy));
        chk({tag, "/done"},   32'(ifa.done),       32'(e_done));
        chk({tag, "/ready"},  32'(ifa.in_ready),   32'(e_rdy));
        chk({tag, "/onehot0"}, 32'($onehot0(ifa.onehot_out)), 32'd1);
`ifdef DEC_PARITY_EN
        chk({tag, "/err"}, 32'(ifa.err), 32'(m_err));
`endif
        m_rdy = e_rdy;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!m_rdy && n < 20) begin
            step(tag);
            n++;
        end
        if (!m_rdy) chk({tag, "/ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_since = NO;
        m_after = 0;
        m_rdy   = 1'b0;
        m_err   = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int last_acc;
        int period;

        tbl[0] = '{3'd0, 8'h01};
        tbl[1] = '{3'd1, 8'h02};
        tbl[2] = '{3'd2, 8'h04};
        tbl[3] = '{3'd3, 8'h08};
        tbl[4] = '{3'd4, 8'h10};
        tbl[5] = '{3'd5, 8'h20};
        tbl[6] = '{3'd6, 8'h40};
        tbl[7] = '{3'd7, 8'h80};

        set_a(3'd0, 1'b0);
        set_b(3'd0, 1'b0);
        do_reset();

        // Reset state, before the first edge after release.
        chk("rst/onehot", 32'(ifa.onehot_out), 32'h0);
        chk("rst/busy",   32'(ifa.busy),       32'h0);
        chk("rst/done",   32'(ifa.done),       32'h0);
        chk("rst/ready",  32'(ifa.in_ready),   32'h0);
`ifdef DEC_PARITY_EN
        chk("rst/err",    32'(ifa.err),        32'h0);
`endif
        step("rst_rise");

        // 1. Single code 5.
        set_a(3'd5, 1'b1);
        step("t1_acc");
        set_a(3'd5, 1'b0);
        chk("t1/first_pulse", 32'(ifa.onehot_out), 32'h20);
        for (int i = 0; i < 6; i++) step("t1");
        chk("t1/ready_after_gap", 32'(ifa.in_ready), 32'h1);

        // 2. Sweep all codes back-to-back; one code per P+G+1 cycles.
        last_acc = -1;
        for (int i = 0; i < 8; i++) begin
            set_a(tbl[i].code, 1'b1);
            wait_ready("t2_wait");
            step("t2_acc");
            chk($sformatf("t2/code%0d", i), 32'(ifa.onehot_out), 32'(tbl[i].exp));
            if (last_acc >= 0) begin
                period = cyc - last_acc;
                chk($sformatf("t2/period%0d", i), 32'(period), 32'(P + G + 1));
            end
            last_acc = cyc;
        end
        set_a(3'd0, 1'b0);
        wait_ready("t2_drain");

        // 3. Code changes mid-DRIVE are ignored.
        set_a(3'd6, 1'b1);
        step("t3_acc");
        set_a(3'd2, 1'b1);
        for (int i = 0; i < P - 1; i++) begin
            step("t3_hold");
            chk("t3/held40", 32'(ifa.onehot_out), 32'h40);
        end
        wait_ready("t3_wait");
        step("t3_acc2");
        chk("t3/new04", 32'(ifa.onehot_out), 32'h04);
        set_a(3'd0, 1'b0);
        wait_ready("t3_drain");

        // 4. Reset on the second DRIVE cycle.
        set_a(3'd3, 1'b1);
        step("t4_acc");
        set_a(3'd3, 1'b0);
        step("t4_drv2");
        rst_n = 1'b0;
        #1;
        chk("t4/async_onehot", 32'(ifa.onehot_out), 32'h0);
        chk("t4/async_busy",   32'(ifa.busy),       32'h0);
        chk("t4/async_ready",  32'(ifa.in_ready),   32'h0);
        do_reset();
        chk("t4/ready_low_after_release", 32'(ifa.in_ready), 32'h0);
        for (int i = 0; i < 4; i++) step("t4_post");

        // 5. DUT B: PULSE_LEN=1, GAP_LEN=0, codes 1 then 7.
        set_b(3'd1, 1'b1);
        step("t5a");
        chk("t5/pulse02", 32'(ifb.onehot_out), 32'h02);
        chk("t5/done1",   32'(ifb.done),       32'h1);
        chk("t5/ready0",  32'(ifb.in_ready),   32'h0);
        set_b(3'd7, 1'b1);
        step("t5b");
        chk("t5/idle_onehot", 32'(ifb.onehot_out), 32'h00);
        chk("t5/idle_ready",  32'(ifb.in_ready),   32'h1);
        chk("t5/idle_busy",   32'(ifb.busy),       32'h0);
        step("t5c");
        chk("t5/pulse80", 32'(ifb.onehot_out), 32'h80);
        chk("t5/done7",   32'(ifb.done),       32'h1);
        set_b(3'd0, 1'b0);
        step("t5d");
        chk("t5/end_onehot", 32'(ifb.onehot_out), 32'h00);

`ifdef DEC_PARITY_EN
        // 6. Bad parity is consumed and flagged, good parity drives.
        wait_ready("t6_wait");
        ifa.in_code  = 3'd3;
        ifa.in_par   = 1'b1;
        ifa.in_valid = 1'b1;
        step("t6_bad");
        chk("t6/err",    32'(ifa.err),        32'h1);
        chk("t6/onehot", 32'(ifa.onehot_out), 32'h0);
        ifa.in_par = 1'b0;
        step("t6_good");
        chk("t6/err_clear", 32'(ifa.err),        32'h0);
        chk("t6/drive08",   32'(ifa.onehot_out), 32'h08);
        set_a(3'd0, 1'b0);
        wait_ready("t6_drain");
`endif

        // Random traffic against the timeline model.
        for (int i = 0; i < 400; i++) begin
            ifa.in_valid = ($urandom_range(0, 3) != 0);
            ifa.in_code  = 3'($urandom);
`ifdef DEC_PARITY_EN
            ifa.in_par = ($urandom_range(0, 4) == 0) ? ~(^ifa.in_code) : ^ifa.in_code;
`endif
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
